// File: rtl/fpu_pkg.sv
// fpu_pkg: shared rounding-mode encodings,
// default field widths and the round-up decision
package fpu_pkg;

  localparam int FPU_EXP_W = 5;
  localparam int FPU_MAN_W = 10;

  typedef enum logic [1:0] {
    RND_RNE = 2'b00,
    RND_RTZ = 2'b01,
    RND_RUP = 2'b10,
    RND_RDN = 2'b11
  } rnd_mode_e;

  // g = guard bit, s = round | sticky
  function automatic logic rnd_inc(
    input rnd_mode_e mode,
    input logic      sign,
    input logic      lsb,
    input logic      g,
    input logic      s
  );
    logic inc;
    unique case (1'b1)
      mode == RND_RNE: inc = g & (s | lsb);
      mode == RND_RUP: inc = (g | s) & !sign;
      mode == RND_RDN: inc = (g | s) & sign;
      default:         inc = 1'b0;
    endcase
    return inc;
  endfunction

endpackage

// File: rtl/fpu_normalize_round_if.sv
// fpu_normalize_round_if: valid/ready bundle around
// the normalize/round block (producer and consumer side)
interface fpu_normalize_round_if
  import fpu_pkg::*;
#(
  parameter int EXP_W = FPU_EXP_W,
  parameter int MAN_W = FPU_MAN_W
);

  logic               in_valid;
  logic               in_ready;
  logic               in_sign;
  logic [EXP_W+1:0]   in_exp;
  logic [MAN_W+3:0]   in_man;
  logic               in_sticky;
  logic [1:0]         rnd_mode;

  logic               out_valid;
  logic               out_ready;
  logic               out_sign;
  logic [EXP_W-1:0]   out_exp;
  logic [MAN_W-1:0]   out_man;
  logic               out_overflow;
  logic               out_underflow;
  logic               out_inexact;
  logic               out_zero;

  modport master (
    output in_valid, in_sign, in_exp,
    output in_man, in_sticky, rnd_mode,
    output out_ready,
    input  in_ready, out_valid, out_sign,
    input  out_exp, out_man, out_overflow,
    input  out_underflow, out_inexact, out_zero
  );

  modport slave (
    input  in_valid, in_sign, in_exp,
    input  in_man, in_sticky, rnd_mode,
    input  out_ready,
    output in_ready, out_valid, out_sign,
    output out_exp, out_man, out_overflow,
    output out_underflow, out_inexact, out_zero
  );

endinterface

// File: rtl/fpu_lzc.sv
// fpu_lzc: leading-zero count from the MSB,
// count = WIDTH when the word is all zero
module fpu_lzc #(
  parameter int WIDTH = 13,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] din,
  output logic [CNT_W-1:0] cnt,
  output logic             all_zero
);

  // scan upward so the highest set bit wins
  always_comb begin
    cnt = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (din[i]) cnt = CNT_W'(WIDTH - 1 - i);
    end
  end

  assign all_zero = ~|din;

endmodule

// File: rtl/fpu_normalize_round.sv
// fpu_normalize_round: S1 normalizes the raw
// mantissa/exponent, S2 rounds, packs and flags
module fpu_normalize_round
  import fpu_pkg::*;
#(
  parameter int EXP_W = FPU_EXP_W,
  parameter int MAN_W = FPU_MAN_W
) (
  input logic clk,
  input logic rst_n,
  fpu_normalize_round_if.slave io
);

  // raw mantissa, internal exponent, lzc widths
  localparam int M  = MAN_W + 4;
  localparam int LW = MAN_W + 3;
  localparam int XE = EXP_W + 3;
  localparam int CW = $clog2(LW + 1);
  localparam int RW = $clog2(M + 1);

  localparam logic signed [XE-1:0] ONE  = XE'(1);
  localparam logic signed [XE-1:0] MAXR = XE'(M);
  localparam logic signed [XE-1:0] EMAX =
    XE'((1 << EXP_W) - 1);

  logic s1_valid;
  logic s2_valid;
  logic s1_adv;
  logic in_fire;

  assign s1_adv      = !s2_valid || io.out_ready;
  assign io.in_ready = rst_n && (!s1_valid || s1_adv);
  assign in_fire     = io.in_valid && io.in_ready;
  assign io.out_valid = s2_valid;

  // ---- S1: normalize ----
  logic signed [XE-1:0] e_in;
  logic signed [XE-1:0] e0;
  logic signed [XE-1:0] e1;
  logic signed [XE-1:0] rdist;
  logic signed [XE-1:0] lim;
  logic signed [XE-1:0] lz_x;
  logic [M-1:0]         m0;
  logic [LW-1:0]        m1;
  logic                 st0;
  logic                 st1;
  logic [CW-1:0]        lz;
  logic                 lz_zero;
  logic [RW-1:0]        rsh;
  logic [CW-1:0]        lsh;

  assign e_in = XE'($signed(io.in_exp));

  // fold a mantissa carry into the exponent first
  always_comb begin
    m0  = io.in_man;
    st0 = io.in_sticky;
    e0  = e_in;
    if (io.in_man[M-1]) begin
      m0  = io.in_man >> 1;
      st0 = io.in_sticky | io.in_man[0];
      e0  = e_in + ONE;
    end
  end

  fpu_lzc #(
    .WIDTH (LW),
    .CNT_W (CW)
  ) u_lzc (
    .din      (m0[LW-1:0]),
    .cnt      (lz),
    .all_zero (lz_zero)
  );

  // left-normalize down to exp 1, or denormalize
  // tiny exponents with sticky collection
  always_comb begin
    rdist = ONE - e0;
    lim   = e0 - ONE;
    lz_x  = $signed({{(XE-CW){1'b0}}, lz});
    rsh   = (rdist > MAXR) ? RW'(M) : rdist[RW-1:0];
    lsh   = (lz_x < lim) ? lz : lim[CW-1:0];
    m1    = m0[LW-1:0];
    st1   = st0;
    e1    = e0;
    if (e0 < ONE) begin
      m1  = LW'(m0 >> rsh);
      st1 = st0 | (|(m0 & ~({M{1'b1}} << rsh)));
      e1  = '0;
    end else if (!io.in_man[M-1]) begin
      m1 = m0[LW-1:0] << lsh;
      e1 = e0 - $signed({{(XE-CW){1'b0}}, lsh});
      if (lz_zero || !m1[LW-1]) e1 = '0;
    end
  end

  logic                 s1_sign;
  rnd_mode_e            s1_rnd;
  logic signed [XE-1:0] s1_exp;
  logic [LW-1:0]        s1_man;
  logic                 s1_sticky;

  // S1 register: word plus captured sign/mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_rnd    <= RND_RNE;
      s1_exp    <= '0;
      s1_man    <= '0;
      s1_sticky <= 1'b0;
    end else begin
      if (io.in_ready) s1_valid <= io.in_valid;
      if (in_fire) begin
        s1_sign   <= io.in_sign;
        s1_rnd    <= rnd_mode_e'(io.rnd_mode);
        s1_exp    <= e1;
        s1_man    <= m1;
        s1_sticky <= st1;
      end
    end
  end

  // ---- S2: round and pack ----
  logic                 g;
  logic                 s;
  logic                 inx;
  logic                 inc;
  logic                 ovf;
  logic                 to_inf;
  logic [MAN_W+1:0]     sum;
  logic signed [XE-1:0] ef;
  logic [MAN_W-1:0]     fr;
  logic [EXP_W-1:0]     eo;
  logic [MAN_W-1:0]     mo;
  logic                 unf;
  logic                 zro;

  // increment, renormalize on carry, saturate
  always_comb begin
    g   = s1_man[1];
    s   = s1_man[0] | s1_sticky;
    inx = g | s;
    inc = rnd_inc(s1_rnd, s1_sign, s1_man[2], g, s);
    sum = {1'b0, s1_man[LW-1:2]}
        + {{(MAN_W+1){1'b0}}, inc};
    ef  = s1_exp;
    fr  = sum[MAN_W-1:0];
    if (sum[MAN_W+1]) begin
      ef = s1_exp + ONE;
      fr = sum[MAN_W:1];
    end else if (s1_exp == '0 && sum[MAN_W]) begin
      ef = ONE;
    end
    ovf    = ef >= EMAX;
    to_inf = (s1_rnd == RND_RNE)
          || (s1_rnd == RND_RUP && !s1_sign)
          || (s1_rnd == RND_RDN && s1_sign);
    eo = ef[EXP_W-1:0];
    mo = fr;
    if (ovf) begin
      eo = to_inf ? '1 : {{(EXP_W-1){1'b1}}, 1'b0};
      mo = to_inf ? '0 : '1;
    end
    unf = (ef == '0) && inx;
    zro = (ef == '0) && (fr == '0);
  end

  logic             o_sign;
  logic [EXP_W-1:0] o_exp;
  logic [MAN_W-1:0] o_man;
  logic             o_ovf;
  logic             o_unf;
  logic             o_inx;
  logic             o_zero;

  // S2 register: held while downstream stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      o_sign   <= 1'b0;
      o_exp    <= '0;
      o_man    <= '0;
      o_ovf    <= 1'b0;
      o_unf    <= 1'b0;
      o_inx    <= 1'b0;
      o_zero   <= 1'b0;
    end else if (s1_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        o_sign <= s1_sign;
        o_exp  <= eo;
        o_man  <= mo;
        o_ovf  <= ovf;
        o_unf  <= unf;
        o_inx  <= inx | ovf;
        o_zero <= zro;
      end
    end
  end

  assign io.out_sign      = o_sign;
  assign io.out_exp       = o_exp;
  assign io.out_man       = o_man;
  assign io.out_overflow  = o_ovf;
  assign io.out_underflow = o_unf;
  assign io.out_inexact   = o_inx;
  assign io.out_zero      = o_zero;

endmodule
